// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
interface rr_arbiter8_if;
  logic [7:0] req_in;
  logic       done_in;
  logic [7:0] gnt_out;
  logic       gnt_valid_out;
  logic       timeout_out;

  modport master (output req_in, done_in, input gnt_out, gnt_valid_out, timeout_out);
  modport slave  (input req_in, done_in, output gnt_out, gnt_valid_out, timeout_out);
endinterface

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with hold limit; grants are held until done,
// request drop or MAX_HOLD cycles, and every grant is followed by an idle cycle.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 15
) (
  input logic        clk_in,
  input logic        rst_in,
  rr_arbiter8_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt, idx, idx_nxt, pick;
  logic [7:0] hold_cnt, hold_nxt, gnt, gnt_nxt;
  logic       gvld, gvld_nxt, tmo, tmo_nxt;
  logic       pick_any, drop, hit_max;

  // Scan offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    pick     = ptr;
    pick_any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (bus.req_in[ptr + 3'(i)]) begin
        pick     = ptr + 3'(i);
        pick_any = 1'b1;
      end
    end
  end

  assign drop    = ~bus.req_in[idx];
  assign hit_max = (hold_cnt == HOLD_LIM);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = idx;
    hold_nxt  = hold_cnt;
    gnt_nxt   = gnt;
    gvld_nxt  = gvld;
    tmo_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = GRANT;
          idx_nxt   = pick;
          gnt_nxt   = 8'd1 << pick;
          gvld_nxt  = 1'b1;
          hold_nxt  = 8'd1;
        end
      end
      GRANT: begin
        if (bus.done_in || drop || hit_max) begin
          state_nxt = IDLE;
          ptr_nxt   = idx + 3'd1;
          gnt_nxt   = 8'h00;
          gvld_nxt  = 1'b0;
          hold_nxt  = 8'd0;
          // Timeout only when the hold limit alone forced the release.
          tmo_nxt   = hit_max & ~bus.done_in & ~drop;
        end else if (hold_cnt != 8'hFF) begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      idx      <= 3'd0;
      hold_cnt <= 8'd0;
      gnt      <= 8'h00;
      gvld     <= 1'b0;
      tmo      <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      idx      <= idx_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      gvld     <= gvld_nxt;
      tmo      <= tmo_nxt;
    end
  end

  assign bus.gnt_out       = gnt;
  assign bus.gnt_valid_out = gvld;
  assign bus.timeout_out   = tmo;
endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 SHALL have parameter: MAX_HOLD, default 15, maximum consecutive grant cycles before forced release (legal 1..255).
REQ-002 SHALL have port: clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_in  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: req_in  input  8  request lines; bit k = requester k.
REQ-005 SHALL have port: done_in  input  1  granted requester finished; release grant.
REQ-006 SHALL have port: gnt_out  output  8  grant vector; one-hot or all-zero; drives downstream 8-to-3 encoder inputs i0..i7.
REQ-007 SHALL have port: gnt_valid_out  output  1  high when gnt_out is non-zero.
REQ-008 SHALL have port: timeout_out  output  1  one-cycle pulse on forced release by MAX_HOLD.
REQ-009 SHALL register all outputs; no combinational path from any input to any output.

Function
REQ-010 SHALL implement a two-state FSM: IDLE, GRANT.
REQ-011 SHALL keep a 3-bit round-robin pointer ptr, the highest-priority index for the next arbitration.
REQ-012 IDLE: if req_in != 0 at a rising edge, SHALL set gnt_out to one-hot of first set bit searching ptr, ptr+1, ... wrapping 7->0, and enter GRANT; latency exactly 1 cycle.
REQ-013 IDLE with req_in == 0 SHALL hold gnt_out = 0, gnt_valid_out = 0.
REQ-014 GRANT: SHALL hold gnt_out unchanged regardless of other req_in bits.
REQ-015 SHALL keep 8-bit hold_cnt: loaded 1 on entering GRANT, incremented each further GRANT cycle, saturating at 255.
REQ-016 GRANT SHALL release at a rising edge when any holds: done_in = 1; granted req_in bit = 0; hold_cnt == MAX_HOLD.
REQ-017 On release SHALL: gnt_out <= 0, gnt_valid_out <= 0, state <= IDLE, ptr <= granted index + 1 mod 8 (7 wraps to 0).
REQ-018 SHALL guarantee at least one all-zero gnt_out cycle between any two grants (back-to-back grants forbidden).
REQ-019 timeout_out SHALL pulse 1 for exactly the cycle after release only when release was caused solely by hold_cnt == MAX_HOLD; done_in or req drop at the same edge SHALL suppress timeout_out.
REQ-020 gnt_out SHALL never have more than one bit set in any cycle.
REQ-021 gnt_valid_out SHALL equal OR-reduce of gnt_out every cycle.
REQ-022 done_in in IDLE SHALL be ignored.
REQ-023 MAX_HOLD = 1 SHALL give grants exactly one cycle long.

Reset
REQ-024 rst_in = 1 at a rising edge SHALL force: state IDLE, ptr 0, hold_cnt 0, gnt_out 8'h00, gnt_valid_out 0, timeout_out 0.
REQ-025 Reset SHALL dominate all other inputs, including mid-GRANT; no timeout_out pulse and no ptr advance from an aborted grant.
REQ-026 First cycle after reset release with req_in != 0 SHALL arbitrate from ptr = 0.

Verification
REQ-027 Reset, req_in = 8'hFF held, done_in pulsed each GRANT cycle -> grants cycle 8'h01, 8'h02, ... 8'h80, 8'h01 with one zero cycle between each.
REQ-028 req_in = 8'h24 from reset -> gnt_out = 8'h04; after done_in, one zero cycle, then 8'h20; next 8'h04 (wrap).
REQ-029 MAX_HOLD = 3, req_in = 8'h08 held, done_in = 0 -> gnt_out = 8'h08 for 3 cycles, then 8'h00 with timeout_out = 1 for one cycle, then 8'h08 again.
REQ-030 Grant 8'h10 active, req_in bit 4 dropped -> gnt_out 8'h00 next cycle, timeout_out stays 0, next grant searches from index 5.
REQ-031 Grant 8'h02 active, rst_in = 1 for one cycle -> all outputs 0 next cycle; with req_in = 8'h06 after reset -> gnt_out = 8'h02 (ptr = 0).
REQ-032 Random req_in/done_in for 10k cycles -> gnt_out always one-hot or zero, gnt_valid_out = |gnt_out, no requester starved beyond 8 grants.
